// File: rtl/fifo_cdc_pkg.sv
// Shared helpers for the async FIFO clock-domain-crossing logic.
package fifo_cdc_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  // Widest pointer the helpers handle; narrower pointers are zero-extended.
  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_max_t;

  // Gray to binary. A zero-extended Gray value converts to a zero-extended binary value.
  function automatic ptr_max_t gray2bin(input ptr_max_t g);
    ptr_max_t b;
    b = '0;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = int'(PTR_MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray.
  function automatic ptr_max_t bin2gray(input ptr_max_t b);
    return b ^ (b >> 1);
  endfunction

  // Number of set bits.
  function automatic int unsigned popcount(input ptr_max_t v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(PTR_MAX_W); i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_bus_chain.sv
// WIDTH x STAGES synchroniser flop chain with synchronous active-low reset.
module sync_bus_chain #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [WIDTH-1:0] stage [STAGES];

  // Plain flop-to-flop chain; only stage[0] samples the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/sync_r2w_gray.sv
// Read-pointer synchroniser into the write domain with binary view, advance
// count and a sticky Gray-coding violation monitor.
module sync_r2w_gray
  import fifo_cdc_pkg::*;
#(
  parameter int unsigned ADDRSIZE    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic [ADDRSIZE:0] rptr,
  input  logic              err_clr,
  output logic [ADDRSIZE:0] wq_rptr,
  output logic [ADDRSIZE:0] wq_rptr_bin,
  output logic [ADDRSIZE:0] rptr_adv,
  output logic              rptr_moved,
  output logic              gray_err
);

  localparam int unsigned PTR_W = ADDRSIZE + 1;

  // Reject illegal configurations at elaboration.
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("sync_r2w_gray: SYNC_STAGES out of range");
  end
  if (PTR_W > PTR_MAX_W) begin : g_bad_width
    $error("sync_r2w_gray: ADDRSIZE too large");
  end

  logic [PTR_W-1:0] prev_gray;
  logic [PTR_W-1:0] cur_bin;
  logic [PTR_W-1:0] prev_bin;
  logic [PTR_W-1:0] adv_next;
  logic             moved_next;
  logic             violation;
  logic             err_next;

  sync_bus_chain #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr),
    .q     (wq_rptr)
  );

  // Binary conversion, advance and Gray-step check on the synchronised pointer.
  always_comb begin
    cur_bin    = '0;
    prev_bin   = '0;
    adv_next   = '0;
    moved_next = 1'b0;
    violation  = 1'b0;
    err_next   = gray_err;

    cur_bin    = PTR_W'(gray2bin(PTR_MAX_W'(wq_rptr)));
    prev_bin   = PTR_W'(gray2bin(PTR_MAX_W'(prev_gray)));
    adv_next   = cur_bin - prev_bin;
    moved_next = (cur_bin != prev_bin);
    violation  = (popcount(PTR_MAX_W'(wq_rptr ^ prev_gray)) > 32'd1);

    // Set has priority over clear so a coincident violation is never lost.
    if (violation) begin
      err_next = 1'b1;
    end else if (err_clr) begin
      err_next = 1'b0;
    end
  end

  // Write-domain registers fed from the synchronised pointer.
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      prev_gray   <= '0;
      wq_rptr_bin <= '0;
      rptr_adv    <= '0;
      rptr_moved  <= 1'b0;
      gray_err    <= 1'b0;
    end else begin
      prev_gray   <= wq_rptr;
      wq_rptr_bin <= cur_bin;
      rptr_adv    <= adv_next;
      rptr_moved  <= moved_next;
      gray_err    <= err_next;
    end
  end

endmodule

// File: tb/tb_sync_r2w_gray.sv
// Bench for sync_r2w_gray: two instances (2 and 4 synchroniser stages) share
// stimulus and are compared every cycle against a history-based reference.
module tb_sync_r2w_gray;

  localparam int unsigned AW   = 4;
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned MAXK = 4096;

  logic          clk = 1'b0;
  logic          wrst_n;
  logic [PW-1:0] rptr;
  logic          err_clr;

  logic [PW-1:0] o_wq   [2];
  logic [PW-1:0] o_bin  [2];
  logic [PW-1:0] o_adv  [2];
  logic          o_mov  [2];
  logic          o_err  [2];

  int tests_run    = 0;
  int tests_failed = 0;

  // Stimulus history, one entry per rising edge.
  logic [PW-1:0] h_rptr [MAXK];
  logic          h_rst  [MAXK];
  logic          h_clr  [MAXK];

  // Expected register contents after each edge, per instance.
  logic [PW-1:0] m_wq   [2][MAXK];
  logic [PW-1:0] m_prev [2][MAXK];
  logic [PW-1:0] m_bin  [2][MAXK];
  logic [PW-1:0] m_adv  [2][MAXK];
  logic          m_mov  [2][MAXK];
  logic          m_err  [2][MAXK];

  int k = 0;

  always #5 clk = ~clk;

  sync_r2w_gray #(.ADDRSIZE(AW), .SYNC_STAGES(2)) dut2 (
    .wclk(clk), .wrst_n(wrst_n), .rptr(rptr), .err_clr(err_clr),
    .wq_rptr(o_wq[0]), .wq_rptr_bin(o_bin[0]), .rptr_adv(o_adv[0]),
    .rptr_moved(o_mov[0]), .gray_err(o_err[0])
  );

  sync_r2w_gray #(.ADDRSIZE(AW), .SYNC_STAGES(4)) dut4 (
    .wclk(clk), .wrst_n(wrst_n), .rptr(rptr), .err_clr(err_clr),
    .wq_rptr(o_wq[1]), .wq_rptr_bin(o_bin[1]), .rptr_adv(o_adv[1]),
    .rptr_moved(o_mov[1]), .gray_err(o_err[1])
  );

  function automatic logic [PW-1:0] to_gray(input int unsigned b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  // Inverse Gray by search: the binary value whose Gray code matches.
  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    for (int unsigned b = 0; b < (1 << PW); b++) begin
      if (to_gray(b) == g) return PW'(b);
    end
    return '0;
  endfunction

  // Synchronised pointer after edge kk: the value sampled S-1 edges earlier,
  // or zero if any reset edge fell inside that window.
  function automatic logic [PW-1:0] exp_wq(input int s, input int kk);
    if (kk - s + 1 < 0) return '0;
    for (int j = kk - s + 1; j <= kk; j++) begin
      if (h_rst[j]) return '0;
    end
    return h_rptr[kk - s + 1];
  endfunction

  task automatic model_edge(input int kk);
    for (int d = 0; d < 2; d++) begin
      int s;
      s = (d == 0) ? 2 : 4;
      m_wq[d][kk] = exp_wq(s, kk);
      if (h_rst[kk] || kk == 0) begin
        m_prev[d][kk] = '0;
        m_bin[d][kk]  = '0;
        m_adv[d][kk]  = '0;
        m_mov[d][kk]  = 1'b0;
        m_err[d][kk]  = 1'b0;
      end else begin
        m_prev[d][kk] = m_wq[d][kk-1];
        m_bin[d][kk]  = g2b(m_wq[d][kk-1]);
        m_adv[d][kk]  = g2b(m_wq[d][kk-1]) - g2b(m_prev[d][kk-1]);
        m_mov[d][kk]  = (m_adv[d][kk] != '0);
        if ($countones(m_wq[d][kk-1] ^ m_prev[d][kk-1]) > 1)
          m_err[d][kk] = 1'b1;
        else if (h_clr[kk])
          m_err[d][kk] = 1'b0;
        else
          m_err[d][kk] = m_err[d][kk-1];
      end
    end
  endtask

  task automatic check(input string tag, input int d, input logic [PW-1:0] obs,
                       input logic [PW-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s s%0d edge %0d: observed %h expected %h", tag, (d == 0) ? 2 : 4,
             k, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then check all outputs of both instances.
  task automatic step(input logic [PW-1:0] r, input logic rst, input logic clr);
    rptr    = r;
    wrst_n  = ~rst;
    err_clr = clr;
    @(posedge clk);
    h_rptr[k] = r;
    h_rst[k]  = rst;
    h_clr[k]  = clr;
    model_edge(k);
    #1;
    for (int d = 0; d < 2; d++) begin
      check("wq_rptr",     d, o_wq[d],         m_wq[d][k]);
      check("wq_rptr_bin", d, o_bin[d],        m_bin[d][k]);
      check("rptr_adv",    d, o_adv[d],        m_adv[d][k]);
      check("rptr_moved",  d, PW'(o_mov[d]),   PW'(m_mov[d][k]));
      check("gray_err",    d, PW'(o_err[d]),   PW'(m_err[d][k]));
    end
    k++;
  endtask

  int unsigned cur_b;

  initial begin
    // Reset held long enough to flush the deeper chain.
    for (int i = 0; i < 4; i++) step('0, 1'b1, 1'b0);

    // Ramp Gray 0 -> 1 -> 3 -> 2, then settle.
    for (int unsigned b = 0; b < 4; b++) step(to_gray(b), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(to_gray(3), 1'b0, 1'b0);

    // Walk up through the wrap 30 -> 31 -> 0 -> 1.
    for (int unsigned b = 4; b < 34; b++) step(to_gray(b % 32), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(to_gray(1), 1'b0, 1'b0);

    // Violation: Gray 0x00 -> 0x03 after a reset, then hold, clear, re-violate with clear.
    for (int i = 0; i < 4; i++) step('0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step('0, 1'b0, 1'b0);
    step(5'h03, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(5'h03, 1'b0, 1'b0);
    step(5'h03, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(5'h03, 1'b0, 1'b0);
    step(5'h00, 1'b0, 1'b0);
    step(5'h00, 1'b0, 1'b0);
    step(5'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(5'h00, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(5'h00, 1'b0, 1'b1);

    // Reset mid-stream with the pointer parked at Gray 0x0A.
    step(5'h0A, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(5'h0A, 1'b0, 1'b1);
    step(5'h0A, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(5'h0A, 1'b0, 1'b0);

    // Long hold.
    for (int i = 0; i < 20; i++) step(5'h0A, 1'b0, 1'b0);

    // Randomised traffic: mostly single steps, some jumps, clears and resets.
    cur_b = 12;
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      if (sel < 60)      cur_b = (cur_b + 1) % 32;
      else if (sel < 70) cur_b = (cur_b + $urandom_range(2, 31)) % 32;
      step(to_gray(cur_b), ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0));
    end
    for (int i = 0; i < 6; i++) step(to_gray(cur_b), 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
